// File: rtl/mprj_io_cfg_seq.sv
// mprj_io_cfg_seq
//   Register-programmable sequencer for the user-area IO pad config bits.
//   Firmware writes shadow copies of REN/OEN and then commits. The committed
//   values are copied onto the pad-facing buses GROUP pads at a time, with
//   groups STAGGER cycles apart, so the pad ring does not switch all at once.
//
//   Register map (write side):
//     0 shadow REN[31:0]    1 shadow REN[NPADS-1:32]
//     2 shadow OEN[31:0]    3 shadow OEN[NPADS-1:32]
//     4 control, bit0 = commit (self-clearing)
//
//   Ports:
//     wb_clk_i   block clock
//     wb_rstn_i  asynchronous active-low reset
//     wr_en      one-cycle register write strobe
//     wr_addr    register index
//     wr_data    write data
//     REN        pad receiver enables, active-low, registered
//     OEN        pad output enables, active-low, registered
//     busy       a sequence is in progress
//     done       one-cycle pulse after the last group has been applied
//     rd_addr    read index   (MPRJ_IO_CFG_RDBK_EN only)
//     rd_data    read data    (MPRJ_IO_CFG_RDBK_EN only)
//
//   Optional feature macro: MPRJ_IO_CFG_RDBK_EN adds a combinational
//   readback port for the shadow registers, busy and the live OEN bus.
//   Without it the read port and its mux do not exist.

module mprj_io_cfg_seq #(
  parameter int NPADS   = 44,
  parameter int GROUP   = 8,
  parameter int STAGGER = 4
) (
  input  logic             wb_clk_i,
  input  logic             wb_rstn_i,
  input  logic             wr_en,
  input  logic [2:0]       wr_addr,
  input  logic [31:0]      wr_data,
`ifdef MPRJ_IO_CFG_RDBK_EN
  input  logic [2:0]       rd_addr,
  output logic [31:0]      rd_data,
`endif
  output logic [NPADS-1:0] REN,
  output logic [NPADS-1:0] OEN,
  output logic             busy,
  output logic             done
);

  localparam int NGRP = (NPADS + GROUP - 1) / GROUP;
  localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam int CW   = (STAGGER > 1) ? $clog2(STAGGER) : 1;

  localparam logic [GW-1:0]    LAST_GRP  = GW'(NGRP - 1);
  localparam logic [CW-1:0]    WAIT_LAST = CW'((STAGGER > 1) ? STAGGER - 2 : 0);
  localparam logic [NPADS-1:0] LO_MASK   = NPADS'(64'h0000_0000_FFFF_FFFF);

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_FIN
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [NPADS-1:0] sh_ren;
  logic [NPADS-1:0] sh_oen;
  logic [NPADS-1:0] sh_ren_nxt;
  logic [NPADS-1:0] sh_oen_nxt;
  logic [NPADS-1:0] stg_ren;
  logic [NPADS-1:0] stg_oen;
  logic [NPADS-1:0] grp_mask;
  logic [GW-1:0]    grp;
  logic [CW-1:0]    wait_cnt;

  logic             commit;
  logic             load_stg;
  logic             apply_grp;
  logic             grp_inc;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             fin;

  assign commit = wr_en && (wr_addr == 3'd4) && wr_data[0];

  // State register.
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control decode. FIN is a settle cycle after the last
  // APPLY; done is registered from it, so the pulse lands one cycle later,
  // when busy has already dropped. Commits outside IDLE are simply dropped.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    load_stg  = 1'b0;
    apply_grp = 1'b0;
    grp_inc   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    fin       = 1'b0;
    case (state)
      S_IDLE: begin
        if (commit) begin
          load_stg  = 1'b1;
          state_nxt = S_APPLY;
        end
      end
      S_APPLY: begin
        busy      = 1'b1;
        apply_grp = 1'b1;
        if (grp == LAST_GRP) begin
          state_nxt = S_FIN;
        end else begin
          grp_inc   = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = (STAGGER > 1) ? S_WAIT : S_APPLY;
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        if (wait_cnt == WAIT_LAST) begin
          state_nxt = S_APPLY;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_FIN: begin
        busy      = 1'b1;
        fin       = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Shadow register write decode; bits above NPADS-1 are dropped.
  always_comb begin
    sh_ren_nxt = sh_ren;
    sh_oen_nxt = sh_oen;
    if (wr_en) begin
      case (wr_addr)
        3'd0: sh_ren_nxt = (sh_ren & ~LO_MASK) | (NPADS'(wr_data) & LO_MASK);
        3'd1: sh_ren_nxt = (sh_ren & LO_MASK) | (NPADS'({wr_data, 32'h0}) & ~LO_MASK);
        3'd2: sh_oen_nxt = (sh_oen & ~LO_MASK) | (NPADS'(wr_data) & LO_MASK);
        3'd3: sh_oen_nxt = (sh_oen & LO_MASK) | (NPADS'({wr_data, 32'h0}) & ~LO_MASK);
        default: ;
      endcase
    end
  end

  // Bits belonging to the current group; the last group is naturally
  // clipped because only NPADS bits exist.
  always_comb begin
    grp_mask = '0;
    for (int i = 0; i < NPADS; i++) begin
      grp_mask[i] = ((i / GROUP) == int'(grp));
    end
  end

  // Datapath: shadow, staging snapshot, group/stagger counters and the
  // registered pad buses. Bits outside the active group keep their value.
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      sh_ren   <= '0;
      sh_oen   <= '1;
      stg_ren  <= '0;
      stg_oen  <= '1;
      REN      <= '0;
      OEN      <= '1;
      grp      <= '0;
      wait_cnt <= '0;
      done     <= 1'b0;
    end else begin
      sh_ren <= sh_ren_nxt;
      sh_oen <= sh_oen_nxt;
      if (load_stg) begin
        stg_ren <= sh_ren;
        stg_oen <= sh_oen;
        grp     <= '0;
      end else if (grp_inc) begin
        grp <= grp + 1'b1;
      end
      if (apply_grp) begin
        REN <= (REN & ~grp_mask) | (stg_ren & grp_mask);
        OEN <= (OEN & ~grp_mask) | (stg_oen & grp_mask);
      end
      if (cnt_clr) begin
        wait_cnt <= '0;
      end else if (cnt_inc) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      done <= fin;
    end
  end

`ifdef MPRJ_IO_CFG_RDBK_EN
  // Combinational readback of shadow, busy and the live OEN bus.
  always_comb begin
    rd_data = 32'h0;
    case (rd_addr)
      3'd0: rd_data = 32'(sh_ren);
      3'd1: rd_data = 32'(sh_ren >> 32);
      3'd2: rd_data = 32'(sh_oen);
      3'd3: rd_data = 32'(sh_oen >> 32);
      3'd4: rd_data = {30'h0, busy, 1'b0};
      3'd5: rd_data = 32'(OEN);
      3'd6: rd_data = 32'(OEN >> 32);
      default: rd_data = 32'h0;
    endcase
  end
`endif

endmodule

// File: tb/tb_mprj_io_cfg_seq.sv
// tb_mprj_io_cfg_seq
//   Self-checking bench for mprj_io_cfg_seq. A timeline model predicts every
//   pad bit from the commit cycle of the running sequence: pad p takes its
//   committed value at T+2+(p/GROUP)*STAGGER, busy covers T+1 up to the last
//   group, done pulses one cycle after that. Directed scenarios are followed
//   by a randomized mix of writes, commits and asynchronous resets.

module tb_mprj_io_cfg_seq;

  parameter int GROUP   = 8;
  parameter int STAGGER = 4;
  localparam int NPADS  = 44;
  localparam int NGRP   = (NPADS + GROUP - 1) / GROUP;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wr_en = 1'b0;
  logic [2:0]       wr_addr = '0;
  logic [31:0]      wr_data = '0;
  logic [NPADS-1:0] ren;
  logic [NPADS-1:0] oen;
  logic             busy;
  logic             done;
`ifdef MPRJ_IO_CFG_RDBK_EN
  logic [2:0]       rd_addr = '0;
  logic [31:0]      rd_data;
`endif

  mprj_io_cfg_seq #(
    .NPADS   (NPADS),
    .GROUP   (GROUP),
    .STAGGER (STAGGER)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rstn_i (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
`ifdef MPRJ_IO_CFG_RDBK_EN
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
`endif
    .REN       (ren),
    .OEN       (oen),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state.
  logic [NPADS-1:0] m_sh_ren, m_sh_oen;
  logic [NPADS-1:0] m_snap_ren, m_snap_oen;
  logic [NPADS-1:0] m_base_ren, m_base_oen;
  bit               m_active;
  int               m_t;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [NPADS-1:0] expBus(input logic [NPADS-1:0] base,
                                              input logic [NPADS-1:0] snap);
    logic [NPADS-1:0] r;
    for (int p = 0; p < NPADS; p++) begin
      if (m_active && cyc >= m_t + 2 + (p / GROUP) * STAGGER) r[p] = snap[p];
      else r[p] = base[p];
    end
    return r;
  endfunction

  function automatic bit expBusy();
    return m_active && cyc >= m_t + 1 && cyc <= m_t + 2 + (NGRP - 1) * STAGGER;
  endfunction

  function automatic bit expDone();
    return m_active && cyc == m_t + 3 + (NGRP - 1) * STAGGER;
  endfunction

  function automatic logic [31:0] upperWord(input logic [NPADS-1:0] v);
    logic [63:0] w;
    w = 64'(v);
    return w[63:32];
  endfunction

  task automatic modelReset();
    m_sh_ren   = '0;
    m_sh_oen   = '1;
    m_snap_ren = '0;
    m_snap_oen = '1;
    m_base_ren = '0;
    m_base_oen = '1;
    m_active   = 1'b0;
    m_t        = 0;
  endtask

  task automatic modelWrite(input logic [2:0] a, input logic [31:0] d);
    logic [NPADS-1:0] cur_ren, cur_oen;
    if (a == 3'd4) begin
      if (d[0] && !expBusy()) begin
        cur_ren    = expBus(m_base_ren, m_snap_ren);
        cur_oen    = expBus(m_base_oen, m_snap_oen);
        m_base_ren = cur_ren;
        m_base_oen = cur_oen;
        m_snap_ren = m_sh_ren;
        m_snap_oen = m_sh_oen;
        m_active   = 1'b1;
        m_t        = cyc;
      end
    end else begin
      for (int p = 0; p < NPADS; p++) begin
        if (a == 3'd0 && p < 32) m_sh_ren[p] = d[p % 32];
        if (a == 3'd1 && p >= 32) m_sh_ren[p] = d[p % 32];
        if (a == 3'd2 && p < 32) m_sh_oen[p] = d[p % 32];
        if (a == 3'd3 && p >= 32) m_sh_oen[p] = d[p % 32];
      end
    end
  endtask

  task automatic checkAll();
    logic [NPADS-1:0] e_oen;
    e_oen = expBus(m_base_oen, m_snap_oen);
    checkOutput("REN", 64'(ren), 64'(expBus(m_base_ren, m_snap_ren)));
    checkOutput("OEN", 64'(oen), 64'(e_oen));
    checkOutput("busy", 64'(busy), 64'(expBusy()));
    checkOutput("done", 64'(done), 64'(expDone()));
`ifdef MPRJ_IO_CFG_RDBK_EN
    begin
      logic [31:0] e_rd;
      case (rd_addr)
        3'd0: e_rd = m_sh_ren[31:0];
        3'd1: e_rd = upperWord(m_sh_ren);
        3'd2: e_rd = m_sh_oen[31:0];
        3'd3: e_rd = upperWord(m_sh_oen);
        3'd4: e_rd = {30'h0, expBusy(), 1'b0};
        3'd5: e_rd = e_oen[31:0];
        3'd6: e_rd = upperWord(e_oen);
        default: e_rd = 32'h0;
      endcase
      checkOutput("rd_data", 64'(rd_data), 64'(e_rd));
    end
`endif
  endtask

  // One clock cycle: check the outputs of this cycle, then drive the inputs
  // that the next rising edge will sample.
  task automatic applyStimulus(input bit we, input logic [2:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    cyc++;
    checkAll();
    wr_en   = we;
    wr_addr = a;
    wr_data = d;
`ifdef MPRJ_IO_CFG_RDBK_EN
    rd_addr = 3'($urandom_range(0, 7));
    #1;
`endif
    if (we) modelWrite(a, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 3'd0, 32'h0);
  endtask

  // Asynchronous reset in the middle of a cycle, checked before any edge.
  task automatic asyncReset(input int hold);
    wr_en = 1'b0;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkAll();
    idle(hold);
    rst_n = 1'b1;
  endtask

  initial begin
    int r;
    modelReset();
    $display("[TB] start GROUP=%0d STAGGER=%0d", GROUP, STAGGER);

    // Reset held for three cycles.
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // OEN shadow to 0, commit, mid-sequence REN shadow write, ignored commit.
    applyStimulus(1'b1, 3'd2, 32'h0);
    applyStimulus(1'b1, 3'd3, 32'h0);
    applyStimulus(1'b1, 3'd4, 32'h1);
    idle(2);
    applyStimulus(1'b1, 3'd0, 32'hFFFF_FFFF);
    idle(1);
    applyStimulus(1'b1, 3'd4, 32'h1);
    idle(22);

    // Second commit picks up the new REN shadow.
    applyStimulus(1'b1, 3'd4, 32'h1);
    idle(26);

    // Reset ten cycles into a sequence, then a full sequence afterwards.
    applyStimulus(1'b1, 3'd2, 32'h0);
    applyStimulus(1'b1, 3'd4, 32'h1);
    idle(10);
    asyncReset(2);
    idle(1);
    applyStimulus(1'b1, 3'd3, 32'h0000_0A5C);
    applyStimulus(1'b1, 3'd1, 32'hFFFF_F3C5);
    applyStimulus(1'b1, 3'd4, 32'h1);
    idle(26);

    // Randomized mix of traffic.
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 1) begin
        asyncReset($urandom_range(1, 2));
      end else if (r < 55) begin
        idle(1);
      end else if (r < 83) begin
        applyStimulus(1'b1, 3'($urandom_range(0, 3)), $urandom);
      end else if (r < 95) begin
        applyStimulus(1'b1, 3'd4, $urandom | 32'h1);
      end else begin
        applyStimulus(1'b1, 3'($urandom_range(4, 7)), $urandom & 32'hFFFF_FFFE);
      end
    end
    idle(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
